alu_word_sequencer: RTL and testbench

//  Multi-cycle controller that runs a word-wide operation on the 4-bit ALU by

---
 rtl/alu_word_sequencer_if.sv | 42 ++++
 rtl/alu_word_sequencer.sv | 133 +++++++++++++
 tb/tb_alu_word_sequencer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_word_sequencer_if.sv
// Bundle of the issue-side and ALU-side signals of the word sequencer.
// master: the issuing logic plus the 4-bit ALU (they drive the sequencer inputs).
// slave:  the sequencer itself.
interface alu_word_sequencer_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // Issue side
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         cin_in;

  // ALU side
  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic         alu_cin;
  logic [2:0]   alu_control;
  logic [3:0]   alu_output;
  logic         alu_cout;

  // Result side
  logic [W-1:0] result;
  logic         cout_out;
  logic         zero;
  logic         busy;
  logic         done;

  modport master (
    output start, op, x, y, cin_in, alu_output, alu_cout,
    input  alu_a, alu_b, alu_cin, alu_control,
    input  result, cout_out, zero, busy, done
  );

  modport slave (
    input  start, op, x, y, cin_in, alu_output, alu_cout,
    output alu_a, alu_b, alu_cin, alu_control,
    output result, cout_out, zero, busy, done
  );
endinterface

// File: rtl/alu_word_sequencer.sv
// Runs a word-wide operation on a 4-bit ALU one nibble per cycle, LSB nibble
// first. Add/sub chain carry/borrow between nibbles; shifts and rotates have
// the bit crossing each nibble boundary patched from the latched operand.
module alu_word_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_word_sequencer_if.slave  bus
);
  localparam int W    = 4 * NIBBLES;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [2:0] OP_LSH  = 3'b100;
  localparam logic [2:0] OP_RSH  = 3'b101;
  localparam logic [2:0] OP_LROT = 3'b110;
  localparam logic [2:0] OP_RROT = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    x_q, y_q;
  logic [2:0]      op_q;
  logic            carry_q;
  logic [IDXW-1:0] idx_q;
  logic [W-1:0]    result_q;
  logic            cout_q;
  logic            zero_q;

  logic            accept;
  logic            last;
  logic            arith;
  logic [IDXW+1:0] bit_base;
  logic            fill_l, fill_r;
  logic [W-1:0]    lsh_word, rsh_word;
  logic [3:0]      lsh_nib, rsh_nib;
  logic [3:0]      patched;
  logic [W-1:0]    result_next;

  assign arith    = (op_q[2:1] == 2'b00);
  assign last     = (idx_q == IDXW'(NIBBLES - 1));
  assign bit_base = {idx_q, 2'b00};

  // Whole-word shifted copies of X: bit 4i of lsh_word is the bit that must
  // enter nibble i from below, bit 4i+3 of rsh_word the bit entering from above.
  assign fill_l   = (op_q == OP_LROT) ? x_q[W-1] : 1'b0;
  assign fill_r   = (op_q == OP_RROT) ? x_q[0]   : 1'b0;
  assign lsh_word = {x_q[W-2:0], fill_l};
  assign rsh_word = {fill_r, x_q[W-1:1]};
  assign lsh_nib  = lsh_word[bit_base +: 4];
  assign rsh_nib  = rsh_word[bit_base +: 4];

  // ALU inputs always come from latched state, so they read 0 after reset.
  assign bus.alu_a   = x_q[bit_base +: 4];
  assign bus.alu_b   = y_q[bit_base +: 4];
  assign bus.alu_cin = arith ? carry_q : 1'b0;
  assign bus.alu_control = (op_q == OP_LROT) ? OP_LSH :
                           (op_q == OP_RROT) ? OP_RSH : op_q;

  assign bus.result   = result_q;
  assign bus.cout_out = cout_q;
  assign bus.zero     = zero_q;
  assign bus.busy     = (state_q == RUN);
  assign bus.done     = (state_q == DONE);

  // Boundary patch of the ALU nibble and the word as it will look after this edge.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned, which would infer a latch.
    patched     = bus.alu_output;
    result_next = result_q;
    case (op_q)
      OP_LSH, OP_LROT: patched = {bus.alu_output[3:1], lsh_nib[0]};
      OP_RSH, OP_RROT: patched = {rsh_nib[3], bus.alu_output[2:0]};
      default:         patched = bus.alu_output;
    endcase
    result_next[bit_base +: 4] = patched;
  end

  // Next-state logic; a Start is only accepted outside RUN.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        accept  = 1'b1;
        state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        accept  = bus.start;
        state_d = bus.start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latch, nibble walk, carry chain and final flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else if (accept) begin
      x_q     <= bus.x;
      y_q     <= bus.y;
      op_q    <= bus.op;
      carry_q <= bus.cin_in;
      idx_q   <= '0;
    end else if (state_q == RUN) begin
      result_q <= result_next;
      if (arith) carry_q <= bus.alu_cout;
      if (last) begin
        idx_q  <= '0;
        cout_q <= arith ? bus.alu_cout : 1'b0;
        zero_q <= (result_next == '0);
      end else begin
        idx_q <= idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_word_sequencer.sv
// Bench for alu_word_sequencer with NIBBLES=4: a behavioural 4-bit ALU answers
// the sequencer, a vector table covers every op, and hand-written sequences
// cover back-to-back Start and reset mid-operation.
module tb_alu_word_sequencer;
  localparam int NIBBLES = 4;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] x;
    logic [15:0] y;
    logic        cin;
    logic [15:0] res;
    logic        cout;
    logic        zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  alu_word_sequencer_if #(.NIBBLES(NIBBLES)) bus ();
  alu_word_sequencer #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Behavioural 4-bit ALU; sub returns a borrow on cout.
  always_comb begin
    logic [4:0] t;
    t = '0;
    case (bus.alu_control)
      3'b000: t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_cin};
      3'b001: t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {4'b0, bus.alu_cin};
      3'b010: t = {1'b0, bus.alu_a | bus.alu_b};
      3'b011: t = {1'b0, bus.alu_a & bus.alu_b};
      3'b100: t = {1'b0, bus.alu_a[2:0], 1'b0};
      3'b101: t = {2'b00, bus.alu_a[3:1]};
      default: t = '0;
    endcase
    bus.alu_output = t[3:0];
    bus.alu_cout   = t[4];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] xval(input int n);
    return 16'((n + 1) * 16'h0123);
  endfunction

  // Issue one op from IDLE and check latency, Busy length, flags and ALU drive.
  task automatic run_op(input vec_t v, input string tag);
    int cycles;
    int busy_cnt;
    logic [2:0] ctrl;
    ctrl = (v.op == 3'b110) ? 3'b100 : (v.op == 3'b111) ? 3'b101 : v.op;
    @(negedge clk);
    bus.op = v.op; bus.x = v.x; bus.y = v.y; bus.cin_in = v.cin; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.x = ~v.x; bus.y = ~v.y; bus.op = ~v.op; bus.cin_in = ~v.cin;
    check({tag, " alu_control"}, 32'(bus.alu_control), 32'(ctrl));
    check({tag, " alu_cin"}, 32'(bus.alu_cin), (v.op[2:1] == 2'b00) ? 32'(v.cin) : 32'd0);
    cycles = 0; busy_cnt = 0;
    while (!bus.done && cycles < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    check({tag, " latency"}, 32'(cycles), 32'd4);
    check({tag, " busy cycles"}, 32'(busy_cnt), 32'd4);
    check({tag, " result"}, 32'(bus.result), 32'(v.res));
    check({tag, " cout"}, 32'(bus.cout_out), 32'(v.cout));
    check({tag, " zero"}, 32'(bus.zero), 32'(v.zero));
    @(negedge clk);
    check({tag, " done one cycle"}, 32'(bus.done), 32'd0);
    check({tag, " result held"}, 32'(bus.result), 32'(v.res));
  endtask

  vec_t vecs[15];

  initial begin
    int dones;
    vecs[0]  = '{3'b000, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[2]  = '{3'b001, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[3]  = '{3'b001, 16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    vecs[4]  = '{3'b010, 16'hF0F0, 16'h0FF0, 1'b0, 16'hFFF0, 1'b0, 1'b0};
    vecs[5]  = '{3'b011, 16'hF0F0, 16'h0FF0, 1'b1, 16'h00F0, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 16'h8001, 16'h0000, 1'b0, 16'h0002, 1'b0, 1'b0};
    vecs[7]  = '{3'b110, 16'h8001, 16'h0000, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[8]  = '{3'b111, 16'h8001, 16'h0000, 1'b0, 16'hC000, 1'b0, 1'b0};
    vecs[9]  = '{3'b101, 16'h0880, 16'h0000, 1'b0, 16'h0440, 1'b0, 1'b0};
    vecs[10] = '{3'b000, 16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
    vecs[11] = '{3'b001, 16'h5000, 16'h1000, 1'b1, 16'h3FFF, 1'b0, 1'b0};
    vecs[12] = '{3'b101, 16'h8001, 16'h0000, 1'b0, 16'h4000, 1'b0, 1'b0};
    vecs[13] = '{3'b001, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1};
    vecs[14] = '{3'b110, 16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b0, 1'b1};

    bus.start = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0; bus.cin_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    check("reset cout", 32'(bus.cout_out), 32'd0);
    check("reset zero", 32'(bus.zero), 32'd0);
    check("reset alu_control", 32'(bus.alu_control), 32'd0);
    check("reset alu_a", 32'(bus.alu_a), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Start held every cycle with X changing: accepts only in IDLE/DONE.
    bus.op = 3'b000; bus.y = '0; bus.cin_in = 1'b0;
    for (int n = 0; n <= 15; n++) begin
      if (n > 0) begin
        @(negedge clk);
        check($sformatf("b2b done n%0d", n), 32'(bus.done), 32'((n % 5) == 0));
        check($sformatf("b2b busy n%0d", n), 32'(bus.busy), 32'((n % 5) != 0));
        if ((n % 5) == 0)
          check($sformatf("b2b result n%0d", n), 32'(bus.result), 32'(xval(n - 5)));
      end
      bus.x = xval(n);
      bus.start = 1'b1;
    end
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    check("b2b drained", 32'(bus.busy), 32'd0);

    // Reset two nibbles into a subtract.
    bus.op = 3'b001; bus.x = 16'h3333; bus.y = 16'h1111; bus.cin_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid-run low byte", 32'(bus.result[7:0]), 32'h22);
    check("mid-run alu_control", 32'(bus.alu_control), 32'd1);
    rst = 1'b1;
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst result", 32'(bus.result), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst alu_control", 32'(bus.alu_control), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no done after reset", 32'(dones), 32'd0);
    run_op(vecs[10], "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
